// File: rtl/parity_pkg.sv
// Shared definitions for the XOR parity scheme, used by both the receive-side
// frame checker and the transmit-side parity generator.
package parity_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    // Single-bit parity sense: 0 for even, 1 for odd.
    function automatic logic parity_sense(input int mode);
        return (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/parity_acc.sv
// 1-bit XOR accumulator with clear/load/enable; clear has priority over load,
// load over enable.
module parity_acc
    import parity_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_en,
    input  logic i_bit,
    output logic o_acc
);

    logic r_acc;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 1'b0;
        end else if (i_clear) begin
            r_acc <= 1'b0;
        end else if (i_load) begin
            r_acc <= i_bit;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_bit;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/parity_frame_checker.sv
// Deserialises DATA_W data bits plus one parity bit, checks XOR parity and
// presents the word on a valid/ready output. Optional: PARITY_ERR_CNT_EN adds err_cnt.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = PARITY_EVEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              sof,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err,
    output logic              frame_valid,
    output logic              busy
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int             CNT_W    = $clog2(DATA_W + 1);
    localparam logic           ODD_BIT  = parity_sense(ODD_PARITY);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_data_out;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_parity_err;
    logic                w_acc;
    logic                w_start;
    logic                w_data_bit;
    logic                w_par_bit;
    logic                w_handshake;

    // A qualified sof starts a frame anywhere except while a result is pending.
    assign w_start     = bit_valid && sof && (r_state != S_OUT);
    assign w_data_bit  = bit_valid && !sof && (r_state == S_DATA);
    assign w_par_bit   = bit_valid && !sof && (r_state == S_PAR);
    assign w_handshake = (r_state == S_OUT) && out_ready;

    parity_acc u_parity_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_handshake),
        .i_load  (w_start),
        .i_en    (w_data_bit),
        .i_bit   (bit_in),
        .o_acc   (w_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default first, so every path assigns the signal and no latch
        // is inferred.
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_next_state = S_DATA;
            S_DATA: begin
                if (w_start) begin
                    w_next_state = S_DATA;
                end else if (w_data_bit && (r_cnt == LAST_IDX)) begin
                    w_next_state = S_PAR;
                end
            end
            S_PAR: begin
                if (w_start) begin
                    w_next_state = S_DATA;
                end else if (w_par_bit) begin
                    w_next_state = S_OUT;
                end
            end
            S_OUT:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_data_out   <= '0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_shift <= DATA_W'(bit_in);
                r_cnt   <= CNT_W'(1);
            end else if (w_data_bit) begin
                r_shift <= r_shift | (DATA_W'(bit_in) << r_cnt);
                r_cnt   <= r_cnt + 1'b1;
            end
            if (w_par_bit) begin
                r_data_out   <= r_shift;
                r_parity_err <= w_acc ^ bit_in ^ ODD_BIT;
            end
        end
    end

    always_comb begin
        busy        = (r_state == S_DATA) || (r_state == S_PAR);
        frame_valid = (r_state == S_OUT);
        data_out    = r_data_out;
        parity_err  = r_parity_err;
    end

`ifdef PARITY_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_handshake && r_parity_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
